// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ packet sources, the write arbiter and the FIFO write port.
// Latency: none (wires only).
// Backpressure: src_ready and fifo_wr_full carry it; this file holds no logic.
// Ports: req/req_len/src_valid/src_data/fifo_wr_full flow towards the arbiter;
//        src_ready/gnt/cur_id/busy/fifo_wr_en/fifo_wr_data flow out of it.
//        master = requesters + FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int IDW   = 2
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       src_valid;
  logic [NREQ*WIDTH-1:0] src_data;
  logic [NREQ-1:0]       src_ready;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        cur_id;
  logic                  busy;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic                  fifo_wr_full;

  modport master (
    output req, req_len, src_valid, src_data, fifo_wr_full,
    input  src_ready, gnt, cur_id, busy, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req, req_len, src_valid, src_data, fifo_wr_full,
    output src_ready, gnt, cur_id, busy, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among NREQ sources.
// Latency: grant one cycle after req in IDLE; beats pass combinationally to the FIFO.
// Backpressure: fifo_wr_full drops src_ready/fifo_wr_en in the same cycle; grant held until last beat.
// Ports: clk, rst (sync, active high), bus (slave side of fifo_wr_arbiter_if).
module fifo_wr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    cur_id_q, cur_id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [LEN_W:0]    beats_left_q, beats_left_d;

  logic              cur_valid;
  logic [WIDTH-1:0]  cur_data;
  logic              beat;
  logic              found;
  logic [IDW-1:0]    sel;
  logic [LEN_W-1:0]  sel_len;
  logic [NREQ-1:0]   src_ready_c;

  // Mux the granted source's valid/data; constant indices keep the selects clean.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_id_q == IDW'(i)) begin
        cur_valid = bus.src_valid[i];
        cur_data  = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin pick: first requester at or after last+1, wrapping modulo NREQ.
  // Outer loop walks priority distance, inner loop matches the index.
  always_comb begin
    found   = 1'b0;
    sel     = last_q;
    sel_len = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && bus.req[i] && (i == (int'(last_q) + k) % NREQ)) begin
          found   = 1'b1;
          sel     = IDW'(i);
          sel_len = bus.req_len[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  // A full flag turns a would-be beat (including the last one) into a stall.
  assign beat = (state_q == XFER) && cur_valid && !bus.fifo_wr_full;

  always_comb begin
    src_ready_c = '0;
    if (state_q == XFER && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cur_id_q == IDW'(i)) begin
          src_ready_c[i] = !bus.fifo_wr_full;
        end
      end
    end
  end

  assign bus.src_ready    = src_ready_c;
  assign bus.fifo_wr_en   = beat && !rst;
  assign bus.fifo_wr_data = cur_data;
  assign bus.gnt          = gnt_q;
  assign bus.cur_id       = cur_id_q;
  assign bus.busy         = (state_q == XFER);

  // Next-state: length is captured once at grant; req/req_len are ignored during XFER.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cur_id_d     = cur_id_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = XFER;
          gnt_d        = NREQ'(1) << sel;
          cur_id_d     = sel;
          last_d       = sel;
          // One extra bit so a length field of all ones yields 2^LEN_W beats.
          beats_left_d = {1'b0, sel_len} + (LEN_W+1)'(1);
        end
      end
      XFER: begin
        if (beat) begin
          if (beats_left_q == (LEN_W+1)'(1)) begin
            state_d      = IDLE;
            gnt_d        = '0;
            beats_left_d = '0;
          end else begin
            beats_left_d = beats_left_q - (LEN_W+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      cur_id_q     <= '0;
      last_q       <= IDW'(NREQ - 1);
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cur_id_q     <= cur_id_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single packet, round robin, full stalls,
// max length with mid-packet changes, and reset mid-packet.
// Inputs change 1ns after the rising edge; outputs are checked 1-2ns later.
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int IDW   = 2;

  logic clk;
  logic rst;
  int   nerr;
  int   nchk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W), .IDW(IDW)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    bus.src_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic set_len(input int i, input logic [LEN_W-1:0] v);
    bus.req_len[i*LEN_W +: LEN_W] = v;
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst  = 1'b1;
    bus.req          = '0;
    bus.req_len      = '0;
    bus.src_valid    = '0;
    bus.src_data     = '0;
    bus.fifo_wr_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_gnt",   32'(bus.gnt),        32'h0);
    chk("rst_busy",  32'(bus.busy),       32'h0);
    chk("rst_curid", 32'(bus.cur_id),     32'h0);
    chk("rst_wren",  32'(bus.fifo_wr_en), 32'h0);
    chk("rst_rdy",   32'(bus.src_ready),  32'h0);

    // Single request: requester 2, 4 beats A0..A3.
    bus.req       = 4'b0100;
    set_len(2, 4'd3);
    bus.src_valid = 4'b1111;
    set_data(2, 16'h00A0);
    #1;
    chk("t1_idle_gnt", 32'(bus.gnt), 32'h0);
    tick();
    bus.req = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      set_data(2, 16'h00A0 + 16'(b));
      #1;
      chk("t1_gnt",  32'(bus.gnt),          32'h4);
      chk("t1_busy", 32'(bus.busy),         32'h1);
      chk("t1_wren", 32'(bus.fifo_wr_en),   32'h1);
      chk("t1_data", 32'(bus.fifo_wr_data), 32'h00A0 + 32'(b));
      chk("t1_rdy",  32'(bus.src_ready),    32'h4);
      tick();
    end
    #1;
    chk("t1_end_busy",  32'(bus.busy),   32'h0);
    chk("t1_end_gnt",   32'(bus.gnt),    32'h0);
    chk("t1_end_curid", 32'(bus.cur_id), 32'h2);

    // Round robin from reset: 0,1,2,3,0,1 with one IDLE cycle between.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'hB000 + 16'(i));
    bus.req_len = '0;
    bus.req     = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_idle_busy", 32'(bus.busy),       32'h0);
      chk("t2_idle_wren", 32'(bus.fifo_wr_en), 32'h0);
      tick();
      #1;
      chk("t2_gnt",   32'(bus.gnt),          32'(1) << (k % 4));
      chk("t2_curid", 32'(bus.cur_id),       32'(k % 4));
      chk("t2_wren",  32'(bus.fifo_wr_en),   32'h1);
      chk("t2_data",  32'(bus.fifo_wr_data), 32'hB000 + 32'(k % 4));
      tick();
    end
    bus.req = 4'b0000;

    // Full backpressure: requester 1, 8 beats, 3 stall cycles after beat 2,
    // plus a full coinciding with the last beat.
    bus.req = 4'b0010;
    set_len(1, 4'd7);
    tick();
    bus.req = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      set_data(1, 16'h00C0 + 16'(b));
      #1;
      chk("t3_wren", 32'(bus.fifo_wr_en),   32'h1);
      chk("t3_data", 32'(bus.fifo_wr_data), 32'h00C0 + 32'(b));
      tick();
    end
    bus.fifo_wr_full = 1'b1;
    set_data(1, 16'h00C2);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t3_full_wren", 32'(bus.fifo_wr_en), 32'h0);
      chk("t3_full_rdy",  32'(bus.src_ready),  32'h0);
      chk("t3_full_busy", 32'(bus.busy),       32'h1);
      tick();
    end
    bus.fifo_wr_full = 1'b0;
    for (int b = 2; b < 7; b++) begin
      set_data(1, 16'h00C0 + 16'(b));
      #1;
      chk("t3_wren", 32'(bus.fifo_wr_en),   32'h1);
      chk("t3_data", 32'(bus.fifo_wr_data), 32'h00C0 + 32'(b));
      chk("t3_rdy",  32'(bus.src_ready),    32'h2);
      tick();
    end
    bus.fifo_wr_full = 1'b1;
    set_data(1, 16'h00C7);
    #1;
    chk("t3_lastfull_wren", 32'(bus.fifo_wr_en), 32'h0);
    tick();
    #1;
    chk("t3_lastfull_busy", 32'(bus.busy), 32'h1);
    bus.fifo_wr_full = 1'b0;
    #1;
    chk("t3_last_wren", 32'(bus.fifo_wr_en),   32'h1);
    chk("t3_last_data", 32'(bus.fifo_wr_data), 32'h00C7);
    tick();
    #1;
    chk("t3_end_busy", 32'(bus.busy), 32'h0);

    // Max length (16 beats) on requester 3 with req/len changed mid-packet,
    // a foreign source valid throughout and one src_valid gap.
    set_data(0, 16'hEEEE);
    bus.req = 4'b1000;
    set_len(3, 4'd15);
    tick();
    bus.req = 4'b0000;
    set_len(3, 4'd2);
    for (int b = 0; b < 16; b++) begin
      if (b == 5) begin
        bus.src_valid[3] = 1'b0;
        #1;
        chk("t4_gap_wren", 32'(bus.fifo_wr_en), 32'h0);
        chk("t4_gap_busy", 32'(bus.busy),       32'h1);
        tick();
        bus.src_valid[3] = 1'b1;
      end
      set_data(3, 16'h0D00 + 16'(b));
      #1;
      chk("t4_wren", 32'(bus.fifo_wr_en),   32'h1);
      chk("t4_data", 32'(bus.fifo_wr_data), 32'h0D00 + 32'(b));
      chk("t4_rdy",  32'(bus.src_ready),    32'h8);
      tick();
    end
    #1;
    chk("t4_end_busy", 32'(bus.busy), 32'h0);
    chk("t4_end_gnt",  32'(bus.gnt),  32'h0);

    // Reset after beat 2 of a 6-beat packet on requester 2.
    bus.req = 4'b0100;
    set_len(2, 4'd5);
    tick();
    for (int b = 0; b < 2; b++) begin
      set_data(2, 16'h00F0 + 16'(b));
      #1;
      chk("t5_wren", 32'(bus.fifo_wr_en), 32'h1);
      chk("t5_gnt",  32'(bus.gnt),        32'h4);
      tick();
    end
    rst     = 1'b1;
    bus.req = 4'b0101;
    #1;
    chk("t5_rst_wren", 32'(bus.fifo_wr_en), 32'h0);
    chk("t5_rst_rdy",  32'(bus.src_ready),  32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_gnt",   32'(bus.gnt),        32'h0);
    chk("t5_post_busy",  32'(bus.busy),       32'h0);
    chk("t5_post_curid", 32'(bus.cur_id),     32'h0);
    chk("t5_post_wren",  32'(bus.fifo_wr_en), 32'h0);
    chk("t5_post_rdy",   32'(bus.src_ready),  32'h0);
    tick();
    #1;
    chk("t5_regnt",      32'(bus.gnt),    32'h1);
    chk("t5_regnt_id",   32'(bus.cur_id), 32'h0);
    chk("t5_regnt_busy", 32'(bus.busy),   32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
